// File: rtl/fp_expand_pkg.sv
// Shared definitions for the 8-bit float <-> linear converters: format widths,
// FSM state encoding and the minimum linear width needed to hold any code exactly.
package fp_expand_pkg;

    localparam int FP_EXP_W  = 3;
    localparam int FP_SIG_W  = 4;
    localparam int LIN_W     = 12;
    localparam int FP_CODE_W = 1 + FP_EXP_W + FP_SIG_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } fp_state_t;

    // Largest magnitude is sig_max << exp_max, so sig_w + 2**exp_w bits hold it with sign.
    function automatic int fp_min_out_w(input int exp_w, input int sig_w);
        return sig_w + (1 << exp_w);
    endfunction

endpackage

// File: rtl/fp_expand_if.sv
// Input and output valid/ready channels of the float expander.
interface fp_expand_if #(
    parameter int CODE_W = 8,
    parameter int OUT_W  = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fp_expand.sv
// Iterative decoder of {sign, exp, sig} float codes into two's-complement linear
// values: one left shift of the significand per clock, then optional negation.
module fp_expand
    import fp_expand_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int SIG_W = FP_SIG_W,
    parameter int OUT_W = LIN_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    output logic            busy,
    fp_expand_if.slave      bus
);

    localparam int CODE_W = 1 + EXP_W + SIG_W;

    if (OUT_W < fp_min_out_w(EXP_W, SIG_W)) begin : g_width_check
        $error("fp_expand: OUT_W too small for EXP_W/SIG_W");
    end

    fp_state_t          state_reg, state_next;
    logic [OUT_W-1:0]   mag_reg, mag_next;
    logic [EXP_W-1:0]   cnt_reg, cnt_next;
    logic               sgn_reg, sgn_next;
    logic [OUT_W-1:0]   out_data_reg, out_data_next;
    logic               out_valid_reg, out_valid_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            mag_reg       <= '0;
            cnt_reg       <= '0;
            sgn_reg       <= 1'b0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mag_reg       <= mag_next;
            cnt_reg       <= cnt_next;
            sgn_reg       <= sgn_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        mag_next       = mag_reg;
        cnt_next       = cnt_reg;
        sgn_next       = sgn_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;

        // Abort wins over everything, including a pending accept in IDLE.
        if (clr) begin
            state_next     = ST_IDLE;
            out_valid_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        mag_next   = {{(OUT_W-SIG_W){1'b0}}, bus.in_code[SIG_W-1:0]};
                        cnt_next   = bus.in_code[SIG_W +: EXP_W];
                        sgn_next   = bus.in_code[CODE_W-1];
                        state_next = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_reg != '0) begin
                        mag_next = mag_reg << 1;
                        cnt_next = cnt_reg - EXP_W'(1);
                    end else begin
                        // Zero magnitude negates to zero, so no negative zero appears.
                        out_data_next  = sgn_reg ? (OUT_W'(0) - mag_reg) : mag_reg;
                        out_valid_next = 1'b1;
                        state_next     = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_next = 1'b0;
                        state_next     = ST_IDLE;
                    end
                end
                default: begin
                    state_next     = ST_IDLE;
                    out_valid_next = 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == ST_IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_fp_expand.sv
// Directed bench for fp_expand: reset, vector table with latencies, backpressure,
// clr/reset aborts and an exhaustive code sweep under random output stalls.
module tb_fp_expand;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic busy;

    int checks = 0;
    int failures = 0;

    fp_expand_if #(.CODE_W(8), .OUT_W(12)) bus ();

    fp_expand #(.EXP_W(3), .SIG_W(4), .OUT_W(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Present one code for a single clock starting at a falling edge.
    task automatic drive_code(input logic [7:0] code);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_code  = code;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Counts rising edges until out_valid is seen; returns 99 if it never comes.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) lat = 99;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 12'h000 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset: out_valid=%b out_data=%h busy=%b in_ready=%b required 0 000 0 1",
                     bus.out_valid, bus.out_data, busy, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: out_valid=%b busy=%b in_ready=%b", bus.out_valid, busy, bus.in_ready);
        end
        $display("reset: done");
    endtask

    task automatic test_vectors();
        logic [7:0]  codes [7] = '{8'h2B, 8'hBB, 8'h7F, 8'hFF, 8'hD0, 8'h01, 8'h8F};
        logic [11:0] datas [7] = '{12'h02C, 12'hFA8, 12'h780, 12'h880, 12'h000, 12'h001, 12'hFF1};
        int          lats  [7] = '{3, 4, 8, 8, 6, 1, 1};
        int lat;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive_code(codes[i]);
            wait_valid(lat);
            checks++;
            if (lat !== lats[i]) begin
                failures++;
                $display("FAIL latency code=%h: got %0d required %0d", codes[i], lat, lats[i]);
            end
            checks++;
            if (bus.out_data !== datas[i]) begin
                failures++;
                $display("FAIL data code=%h: got %h required %h", codes[i], bus.out_data, datas[i]);
            end
            checks++;
            if (bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL in_ready_hold code=%h: got %b required 0", codes[i], bus.in_ready);
            end
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL consume code=%h: in_ready=%b out_valid=%b required 1 0",
                         codes[i], bus.in_ready, bus.out_valid);
            end
            $display("vector code=%h data=%h latency=%0d", codes[i], bus.out_data, lat);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bus.out_ready = 1'b0;
        drive_code(8'h35);
        wait_valid(lat);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 12'h028 || bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold cycle %0d: out_valid=%b out_data=%h in_ready=%b required 1 028 0",
                         c, bus.out_valid, bus.out_data, bus.in_ready);
            end
            bus.in_valid = (c == 2);
            bus.in_code  = 8'h7F;
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 10; c++) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ignored_input: out_valid=%b busy=%b required 0 0", bus.out_valid, busy);
        end
        $display("backpressure: held %h for 5 stalled clocks", bus.out_data);
    endtask

    task automatic test_abort();
        bus.out_ready = 1'b1;
        drive_code(8'h71);
        @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 12'h028) begin
            failures++;
            $display("FAIL clr_abort: busy=%b in_ready=%b out_valid=%b out_data=%h required 0 1 0 028",
                     busy, bus.in_ready, bus.out_valid, bus.out_data);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                checks++;
                failures++;
                $display("FAIL clr_no_output: out_valid=1 at cycle %0d required 0", c);
            end
        end
        clr = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_code  = 8'h12;
        @(negedge clk);
        clr = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL clr_blocks_accept: busy=%b required 0", busy);
        end
        drive_code(8'h71);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || bus.out_data !== 12'h000 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_abort: busy=%b out_data=%h out_valid=%b in_ready=%b required 0 000 0 1",
                     busy, bus.out_data, bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("abort: clr and rst_n aborts done");
    endtask

    task automatic test_round_trip();
        int          val;
        logic [11:0] expv;
        logic [7:0]  code;
        logic        got, done;
        int          bad = 0;
        for (int k = 0; k < 256; k++) begin
            code = 8'(k);
            val  = int'(code[3:0]) << code[6:4];
            if (code[7]) val = -val;
            expv = 12'(val);
            drive_code(code);
            got  = 1'b0;
            done = 1'b0;
            for (int c = 0; c < 60 && !done; c++) begin
                if (bus.out_valid) begin
                    checks++;
                    if (bus.out_data !== expv) begin
                        failures++;
                        bad++;
                        $display("FAIL round_trip code=%h: got %h required %h", code, bus.out_data, expv);
                    end
                    got = 1'b1;
                end
                bus.out_ready = 1'($urandom_range(0, 1));
                if (bus.out_valid && bus.out_ready) done = 1'b1;
                @(posedge clk);
                @(negedge clk);
            end
            if (!done) begin
                checks++;
                failures++;
                $display("FAIL round_trip_timeout code=%h: got_valid=%b required completed handshake", code, got);
            end
        end
        $display("round_trip: 256 codes swept, %0d bad", bad);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_code   = 8'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_abort();
        test_round_trip();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
